hailstone_engine: RTL
=====================

HAILSTONE_ENGINE -- requirements
Module: hailstone_engine

Interface
REQ-001 Parameter WIDTH, default 16: bit width of the operand n and of every datapath register.
REQ-002 Parameter CNT_WIDTH, default 16: bit width of the step counter.
REQ-003 Parameter MAX_STEPS, default 1000: step budget before a run aborts with a timeout.
REQ-004 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  request to begin a run; sampled only while ready=1.
REQ-007 Port n_in  input  WIDTH  starting value; captured on the accepting edge.
REQ-008 Port ready  output  1  high only in IDLE.
REQ-009 Port busy  output  1  high only in RUN.
REQ-010 Port done  output  1  high for exactly one cycle, in DONE.
REQ-011 Port n_cur  output  WIDTH  current or final value of n.
REQ-012 Port steps  output  CNT_WIDTH  number of completed steps.
REQ-013 Port peak  output  WIDTH  largest value of n reached in the run, including n_in.
REQ-014 Port err  output  2  run status: 00 ok, 01 overflow, 10 timeout, 11 zero input.

Function
REQ-015 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL be registered.
REQ-016 In IDLE with start=1, the next edge SHALL load n_cur=n_in, peak=n_in, steps=0 and err=00, and SHALL enter RUN.
REQ-017 A start while in RUN or DONE SHALL be ignored, with no side effects.
REQ-018 In RUN, each edge SHALL evaluate, in priority order:
- n_cur==0: err=11, go to DONE.
- n_cur==1: go to DONE, err=00.
- steps==MAX_STEPS: err=10, go to DONE.
- Otherwise perform one step.
REQ-019 Even step: n_cur = n_cur>>1, steps+1.
REQ-020 Odd step: compute 3*n_cur+1 at WIDTH+2 bits.
- If the result exceeds 2^WIDTH-1: err=01, go to DONE; n_cur and steps are unchanged.
- Else: n_cur = result, steps+1.
REQ-021 peak SHALL update to the new n_cur on the same edge whenever the new n_cur > peak.
REQ-022 The steps counter SHALL saturate at 2^CNT_WIDTH-1 and SHALL never wrap.
REQ-023 DONE SHALL last exactly one cycle and return to IDLE on the next edge.
REQ-024 n_cur, steps, peak and err SHALL hold their final values until the next accepted start.
REQ-025 Latency: for a successful run of S steps, done SHALL go high S+1 edges after the accepting edge; for n_in=1 that is 1 edge.
REQ-026 Exactly one step per clock in RUN; no multi-cycle arithmetic.

Reset
REQ-027 reset=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, ready=1;
- busy=0, done=0;
- n_cur=0, steps=0, peak=0, err=00.
REQ-028 A reset asserted mid-run SHALL abort the run; no done pulse SHALL follow.
REQ-029 start SHALL be ignored while reset=1; the first edge after deassertion SHALL be able to accept a start.

Verification
REQ-030 WIDTH=16, n_in=6 -> done 9 edges after accept; steps=8, peak=16, n_cur=1, err=00.
REQ-031 WIDTH=16, n_in=27 -> steps=111, peak=9232, n_cur=1, err=00; busy high for 112 cycles.
REQ-032 WIDTH=8, n_in=27 -> err=01, steps=11, n_cur=107, peak=214.
REQ-033 MAX_STEPS=10, n_in=7 -> err=10, steps=10, n_cur=10, peak=52.
REQ-034 n_in=0 -> done 1 edge after accept; err=11, steps=0, peak=0.
REQ-035 n_in=7, reset pulsed after 5 steps, then start with n_in=1 ->
- No done pulse for the aborted run.
- All outputs at reset values until the new accept.
- Second run: steps=0, err=00, done 1 edge after accept.
- A start pulsed during RUN is ignored throughout.

Source files
------------

// File: rtl/hailstone_engine.sv
`default_nettype none
// hailstone_engine: iterates the Collatz map on n_in at one step per clock,
// tracking step count, peak value and an abort status (overflow/timeout/zero).
module hailstone_engine #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned MAX_STEPS = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     n_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     n_cur,
  output logic [CNT_WIDTH-1:0] steps,
  output logic [WIDTH-1:0]     peak,
  output logic [1:0]           err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]           ERR_OK   = 2'b00;
  localparam logic [1:0]           ERR_OVF  = 2'b01;
  localparam logic [1:0]           ERR_TMO  = 2'b10;
  localparam logic [1:0]           ERR_ZERO = 2'b11;
  localparam logic [WIDTH-1:0]     N_ONE    = 1;
  localparam logic [WIDTH+1:0]     T_ONE    = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  state_t                 state_q;
  logic                   ready_q, busy_q, done_q;
  logic [WIDTH-1:0]       n_cur_q, peak_q;
  logic [CNT_WIDTH-1:0]   steps_q;
  logic [1:0]             err_q;

  logic [WIDTH+1:0]       triple;
  logic [WIDTH-1:0]       n_next;
  logic                   finish;
  logic [1:0]             fin_err;

  // Two guard bits make 3n+1 exact so overflow is just a nonzero top slice.
  assign triple = ({2'b00, n_cur_q} << 1) + {2'b00, n_cur_q} + T_ONE;
  assign n_next = n_cur_q[0] ? triple[WIDTH-1:0] : (n_cur_q >> 1);

  always_comb begin
    finish  = 1'b1;
    fin_err = ERR_OK;
    if (n_cur_q == '0) begin
      fin_err = ERR_ZERO;
    end else if (n_cur_q == N_ONE) begin
      fin_err = ERR_OK;
    end else if (32'(steps_q) == MAX_STEPS) begin
      fin_err = ERR_TMO;
    end else if (n_cur_q[0] && (triple[WIDTH+1:WIDTH] != 2'b00)) begin
      fin_err = ERR_OVF;
    end else begin
      finish  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      n_cur_q <= '0;
      peak_q  <= '0;
      steps_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            n_cur_q <= n_in;
            peak_q  <= n_in;
            steps_q <= '0;
            err_q   <= ERR_OK;
          end
        end
        RUN: begin
          if (finish) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= fin_err;
          end else begin
            n_cur_q <= n_next;
            if (steps_q != CNT_MAX) begin
              steps_q <= steps_q + CNT_ONE;
            end
            if (n_next > peak_q) begin
              peak_q <= n_next;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign n_cur = n_cur_q;
  assign steps = steps_q;
  assign peak  = peak_q;
  assign err   = err_q;

endmodule
`default_nettype wire
